// File: rtl/bus_pkg.sv
// Shared definitions for the bus target: width encodings, FSM states and
// the byte-lane steering helpers used for both writes and reads.
// Lane convention: big-endian within a phrase, so the byte at address[2:0]=k
// occupies data[63-8k -: 8], which is byte-enable bit 7-k.
package bus_pkg;

  localparam logic [3:0] W_BYTE   = 4'b0001;
  localparam logic [3:0] W_WORD   = 4'b0010;
  localparam logic [3:0] W_LONG   = 4'b0100;
  localparam logic [3:0] W_PHRASE = 4'b1000;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, ACK} state_e;

  // be   : byte enables (bit i covers data[8i+7:8i])
  // sh   : bit distance from lane 0 to the lowest addressed lane
  // data : write data already placed on the addressed lanes
  typedef struct packed {
    logic [7:0]  be;
    logic [5:0]  sh;
    logic [63:0] data;
  } lanes_t;

  function automatic logic [63:0] lane_mask(input logic [7:0] be);
    logic [63:0] m;
    m = '0;
    for (int unsigned i = 0; i < 8; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  // Non-one-hot widths yield be='0, so the access writes nothing and reads 0.
  function automatic lanes_t steer(input logic [3:0]  width,
                                   input logic [2:0]  off,
                                   input logic        justify,
                                   input logic [63:0] wdata);
    lanes_t     r;
    logic [3:0] nb;
    logic [2:0] a;
    logic [8:0] m9;
    r = '0;
    case (width)
      W_BYTE:   nb = 4'd1;
      W_WORD:   nb = 4'd2;
      W_LONG:   nb = 4'd4;
      W_PHRASE: nb = 4'd8;
      default:  nb = 4'd0;
    endcase
    if (nb != 4'd0) begin
      a      = off & ~3'(nb - 4'd1);
      r.sh   = {3'(4'd8 - {1'b0, a} - nb), 3'b000};
      m9     = (9'd1 << nb) - 9'd1;
      r.be   = m9[7:0] << r.sh[5:3];
      r.data = (justify ? (wdata << r.sh) : wdata) & lane_mask(r.be);
    end
    return r;
  endfunction

  function automatic logic [63:0] gather(input logic [63:0] phrase,
                                         input lanes_t      l,
                                         input logic        justify);
    logic [63:0] v;
    v = phrase & lane_mask(l.be);
    return justify ? (v >> l.sh) : v;
  endfunction

endpackage

// File: rtl/bus_target_ram.sv
// Synchronous single-port phrase RAM with per-byte write enables.
// Ports: clk_i clock; en_i access strobe; be_i byte enables (write);
//        addr_i phrase address; wdata_i write data; rdata_o read data,
//        valid the cycle after an enabled access (returns pre-write data).
module bus_target_ram
  import bus_pkg::*;
#(
  parameter int unsigned AW = 10
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic [7:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [63:0]   wdata_i,
  output logic [63:0]   rdata_o
);

  logic [63:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
      rdata_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/bus_target.sv
// Memory-mapped bus responder backed by a private byte-enabled phrase RAM.
// Ports: sys_clk clock; reset_n sync active-low reset; clk_en bus-cycle
//        strobe; mreq/read/width/justify/address/wdata initiator cycle;
//        ack/ack_oe completion strobe and its drive enable;
//        rdata/rdata_oe read data and its drive enable; busy = not IDLE.
module bus_target
  import bus_pkg::*;
#(
  parameter logic [23:0] BASE        = 24'hF1B000,
  parameter int unsigned SIZE_LOG2   = 13,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic        mreq,
  input  logic        read,
  input  logic [3:0]  width,
  input  logic        justify,
  input  logic [23:0] address,
  input  logic [63:0] wdata,
  output logic        ack,
  output logic        ack_oe,
  output logic [63:0] rdata,
  output logic        rdata_oe,
  output logic        busy
);

  state_e               state_q;
  logic [3:0]           cnt_q;
  logic                 rd_q;
  logic [3:0]           width_q;
  logic                 just_q;
  logic [SIZE_LOG2-1:0] addr_q;
  logic [63:0]          wdata_q;
  logic                 ack_q;
  logic                 ack_oe_q;
  logic                 rdata_oe_q;

  logic                 hit;
  lanes_t               lanes;
  logic [63:0]          ram_rdata;

  assign hit   = mreq && (address[23:SIZE_LOG2] == BASE[23:SIZE_LOG2]);
  assign lanes = steer(width_q, addr_q[2:0], just_q, wdata_q);

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_q       <= 1'b0;
      width_q    <= '0;
      just_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ack_q      <= 1'b0;
      ack_oe_q   <= 1'b0;
      rdata_oe_q <= 1'b0;
    end else if (clk_en) begin
      ack_q      <= 1'b0;
      ack_oe_q   <= 1'b0;
      rdata_oe_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hit) begin
            rd_q    <= read;
            width_q <= width;
            just_q  <= justify;
            addr_q  <= address[SIZE_LOG2-1:0];
            wdata_q <= wdata;
            if (WAIT_STATES == 0) begin
              state_q <= ACCESS;
            end else begin
              state_q <= WAIT;
              cnt_q   <= 4'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) state_q <= ACCESS;
          else             cnt_q   <= cnt_q - 4'd1;
        end
        ACCESS: begin
          state_q    <= ACK;
          ack_q      <= 1'b1;
          ack_oe_q   <= 1'b1;
          rdata_oe_q <= rd_q;
        end
        ACK: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // The RAM is accessed on the ACCESS edge; its registered output is valid
  // throughout ACK, so read data is lane-selected from it and gated by the
  // registered rdata_oe, which also forces 0 outside ACK.
  bus_target_ram #(
    .AW(SIZE_LOG2 - 3)
  ) u_ram (
    .clk_i   (sys_clk),
    .en_i    (clk_en && (state_q == ACCESS)),
    .be_i    (rd_q ? 8'h00 : lanes.be),
    .addr_i  (addr_q[SIZE_LOG2-1:3]),
    .wdata_i (lanes.data),
    .rdata_o (ram_rdata)
  );

  assign ack      = ack_q;
  assign ack_oe   = ack_oe_q;
  assign rdata_oe = rdata_oe_q;
  assign rdata    = rdata_oe_q ? gather(ram_rdata, lanes, just_q) : '0;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_bus_target.sv
module tb_bus_target;

  localparam int WS = 2;

  logic        sys_clk = 1'b0;
  logic        reset_n, clk_en, mreq, read, justify;
  logic [3:0]  width;
  logic [23:0] address;
  logic [63:0] wdata;
  logic        ack, ack_oe, rdata_oe, busy;
  logic [63:0] rdata;

  int checks = 0;
  int passes = 0;

  // Byte-addressed reference image of the 8 KiB window.
  logic [7:0] mm [0:8191];

  always #5 sys_clk = ~sys_clk;

  bus_target #(
    .BASE(24'hF1B000),
    .SIZE_LOG2(13),
    .WAIT_STATES(WS)
  ) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .clk_en(clk_en), .mreq(mreq),
    .read(read), .width(width), .justify(justify), .address(address),
    .wdata(wdata), .ack(ack), .ack_oe(ack_oe), .rdata(rdata),
    .rdata_oe(rdata_oe), .busy(busy)
  );

  function automatic int unsigned nbytes(input logic [3:0] w);
    case (w)
      4'b0001: return 1;
      4'b0010: return 2;
      4'b0100: return 4;
      4'b1000: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic logic [63:0] m_read(input logic [3:0] w, input int unsigned off, input logic j);
    int unsigned n, b;
    logic [63:0] r;
    n = nbytes(w);
    r = '0;
    if (n == 0) return r;
    b = off - (off % n);
    for (int unsigned i = 0; i < n; i++) begin
      if (j) r = (r << 8) | 64'(mm[b+i]);
      else   r = r | (64'(mm[b+i]) << (8 * (7 - ((b + i) % 8))));
    end
    return r;
  endfunction

  task automatic m_write(input logic [3:0] w, input int unsigned off, input logic j, input logic [63:0] d);
    int unsigned n, b;
    n = nbytes(w);
    if (n == 0) return;
    b = off - (off % n);
    for (int unsigned i = 0; i < n; i++) begin
      if (j) mm[b+i] = 8'(d >> (8 * (n - 1 - i)));
      else   mm[b+i] = 8'(d >> (8 * (7 - ((b + i) % 8))));
    end
  endtask

  // Called just after a negedge. Drives one cycle, counts enabled and raw
  // edges up to the ack sample. Unless hold, drops mreq and steps one edge
  // to observe the post-ACK outputs.
  task automatic run_cycle(input logic rd, input logic [3:0] w, input logic j,
                           input logic [23:0] a, input logic [63:0] d,
                           input logic hold, input logic scr,
                           input int stall_at, input int stall_len,
                           output logic [63:0] rdat, output int en_lat, output int clk_lat,
                           output logic aoe, output logic roe, output logic early,
                           output logic tmo, output logic post_zero);
    logic en_now, stalled;
    int   stall_rem;
    mreq = 1'b1; read = rd; width = w; justify = j; address = a; wdata = d;
    en_lat = 0; clk_lat = 0; tmo = 1'b1; early = 1'b0; stall_rem = 0; stalled = 1'b0;
    rdat = '0; aoe = 1'b0; roe = 1'b0; post_zero = 1'b1;
    for (int k = 0; k < 100; k++) begin
      en_now = clk_en;
      @(posedge sys_clk);
      clk_lat++;
      if (en_now) en_lat++;
      @(negedge sys_clk);
      if (ack === 1'b1) begin
        tmo = 1'b0;
        break;
      end
      if (ack_oe !== 1'b0 || rdata_oe !== 1'b0 || rdata !== 64'h0) early = 1'b1;
      if (scr && en_lat >= 1) begin
        read = 1'($urandom); justify = 1'($urandom); width = 4'($urandom);
        address = 24'hF1B000 + 24'($urandom_range(0, 8191));
        wdata = {$urandom, $urandom};
      end
      if (stall_rem > 0) begin
        stall_rem--;
        if (stall_rem == 0) clk_en = 1'b1;
      end else if (!stalled && stall_len > 0 && en_lat == stall_at) begin
        clk_en = 1'b0;
        stall_rem = stall_len;
        stalled = 1'b1;
      end
    end
    aoe = ack_oe; roe = rdata_oe; rdat = rdata; clk_en = 1'b1;
    if (!hold) begin
      mreq = 1'b0;
      @(posedge sys_clk);
      @(negedge sys_clk);
      post_zero = (ack === 1'b0 && ack_oe === 1'b0 && rdata_oe === 1'b0 &&
                   rdata === 64'h0 && busy === 1'b0);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; clk_en = 1'b0; mreq = 1'b0; read = 1'b0; justify = 1'b0;
    width = 4'b0; address = '0; wdata = '0;
    repeat (3) @(negedge sys_clk);
    checks++;
    if ({ack, ack_oe, rdata_oe, busy} !== 4'b0000) $display("FAIL reset_ctl: got %b expected 0000", {ack, ack_oe, rdata_oe, busy});
    else passes++;
    checks++;
    if (rdata !== 64'h0) $display("FAIL reset_rdata: got %h expected 0", rdata);
    else passes++;
    clk_en = 1'b1;
    @(negedge sys_clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy_en: got %b expected 0", busy);
    else passes++;
    reset_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic init_mem;
    logic [63:0] r, d;
    int el, cl;
    logic aoe, roe, early, tmo, pz;
    for (int unsigned o = 0; o < 64; o += 8) begin
      d = {$urandom, $urandom};
      run_cycle(1'b0, 4'b1000, 1'b0, 24'hF1B000 + 24'(o), d, 1'b0, 1'b0, 0, 0, r, el, cl, aoe, roe, early, tmo, pz);
      m_write(4'b1000, o, 1'b0, d);
      checks++;
      if ({tmo, aoe, roe, early, pz} !== 5'b01001 || el != WS + 2)
        $display("FAIL init_write: flags %b lat %0d expected 01001 lat %0d", {tmo, aoe, roe, early, pz}, el, WS + 2);
      else passes++;
    end
  endtask

  task automatic test_long_rw;
    logic [63:0] r;
    int el, cl;
    logic aoe, roe, early, tmo, pz;
    run_cycle(1'b0, 4'b0100, 1'b1, 24'hF1B004, 64'hDEADBEEF, 1'b0, 1'b0, 0, 0, r, el, cl, aoe, roe, early, tmo, pz);
    m_write(4'b0100, 4, 1'b1, 64'hDEADBEEF);
    checks++;
    if ({tmo, aoe, roe, early, pz} !== 5'b01001) $display("FAIL long_wr_flags: got %b expected 01001", {tmo, aoe, roe, early, pz});
    else passes++;
    checks++;
    if (el != 4) $display("FAIL long_wr_latency: got %0d expected 4", el);
    else passes++;
    run_cycle(1'b1, 4'b0100, 1'b1, 24'hF1B004, 64'h0, 1'b0, 1'b0, 0, 0, r, el, cl, aoe, roe, early, tmo, pz);
    checks++;
    if ({tmo, aoe, roe, early, pz} !== 5'b01101) $display("FAIL long_rd_flags: got %b expected 01101", {tmo, aoe, roe, early, pz});
    else passes++;
    checks++;
    if (el != 4) $display("FAIL long_rd_latency: got %0d expected 4", el);
    else passes++;
    checks++;
    if (r !== 64'h00000000DEADBEEF) $display("FAIL long_rd_data: got %h expected 00000000deadbeef", r);
    else passes++;
  endtask

  task automatic test_byte_phrase;
    logic [63:0] r, exp;
    int el, cl;
    logic aoe, roe, early, tmo, pz;
    run_cycle(1'b0, 4'b0001, 1'b1, 24'hF1B002, 64'hFFFF_FFFF_FFFF_FFA5, 1'b0, 1'b0, 0, 0, r, el, cl, aoe, roe, early, tmo, pz);
    m_write(4'b0001, 2, 1'b1, 64'hFFFF_FFFF_FFFF_FFA5);
    run_cycle(1'b1, 4'b1000, 1'b0, 24'hF1B000, 64'h0, 1'b0, 1'b0, 0, 0, r, el, cl, aoe, roe, early, tmo, pz);
    exp = m_read(4'b1000, 0, 1'b0);
    checks++;
    if (r[47:40] !== 8'hA5) $display("FAIL byte_lane: got %h expected a5", r[47:40]);
    else passes++;
    checks++;
    if (r !== exp) $display("FAIL phrase_rd: got %h expected %h", r, exp);
    else passes++;
  endtask

  task automatic test_miss;
    mreq = 1'b1; read = 1'b1; width = 4'b0100; justify = 1'b1; address = 24'hF1C000;
    for (int k = 0; k < 20; k++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      checks++;
      if ({ack, ack_oe, busy} !== 3'b000) $display("FAIL miss_cycle%0d: got %b expected 000", k, {ack, ack_oe, busy});
      else passes++;
    end
    mreq = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [63:0] r;
    int el, cl;
    logic aoe, roe, early, tmo, pz;
    run_cycle(1'b1, 4'b1000, 1'b0, 24'hF1B000, 64'h0, 1'b1, 1'b0, 0, 0, r, el, cl, aoe, roe, early, tmo, pz);
    checks++;
    if (r !== m_read(4'b1000, 0, 1'b0) || tmo !== 1'b0) $display("FAIL b2b_first: got %h expected %h", r, m_read(4'b1000, 0, 1'b0));
    else passes++;
    run_cycle(1'b1, 4'b1000, 1'b0, 24'hF1B008, 64'h0, 1'b0, 1'b0, 0, 0, r, el, cl, aoe, roe, early, tmo, pz);
    checks++;
    if (el != WS + 3) $display("FAIL b2b_spacing: got %0d expected %0d", el, WS + 3);
    else passes++;
    checks++;
    if (r !== m_read(4'b1000, 8, 1'b0) || {tmo, early, pz} !== 3'b001)
      $display("FAIL b2b_second: got %h flags %b expected %h flags 001", r, {tmo, early, pz}, m_read(4'b1000, 8, 1'b0));
    else passes++;
  endtask

  task automatic test_reset_abort;
    logic [63:0] r;
    int el, cl;
    logic aoe, roe, early, tmo, pz;
    mreq = 1'b1; read = 1'b0; width = 4'b0010; justify = 1'b1; address = 24'hF1B004; wdata = 64'h1234;
    @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (busy !== 1'b1) $display("FAIL abort_busy: got %b expected 1", busy);
    else passes++;
    reset_n = 1'b0; mreq = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if ({ack, ack_oe, rdata_oe, busy} !== 4'b0000 || rdata !== 64'h0)
      $display("FAIL abort_outputs: got %b rdata %h expected 0000 rdata 0", {ack, ack_oe, rdata_oe, busy}, rdata);
    else passes++;
    reset_n = 1'b1;
    @(negedge sys_clk);
    run_cycle(1'b1, 4'b0010, 1'b1, 24'hF1B004, 64'h0, 1'b0, 1'b0, 0, 0, r, el, cl, aoe, roe, early, tmo, pz);
    checks++;
    if (r !== 64'hDEAD) $display("FAIL abort_old_word: got %h expected dead", r);
    else passes++;
  endtask

  task automatic test_illegal_stall;
    logic [63:0] r, exp;
    int el, cl;
    logic aoe, roe, early, tmo, pz;
    run_cycle(1'b0, 4'b0110, 1'b0, 24'hF1B010, {$urandom, $urandom}, 1'b0, 1'b0, 0, 0, r, el, cl, aoe, roe, early, tmo, pz);
    m_write(4'b0110, 16, 1'b0, 64'h0);
    checks++;
    if ({tmo, aoe, roe, pz} !== 4'b0101 || el != 4) $display("FAIL illegal_ack: flags %b lat %0d expected 0101 lat 4", {tmo, aoe, roe, pz}, el);
    else passes++;
    run_cycle(1'b1, 4'b0100, 1'b1, 24'hF1B010, 64'h0, 1'b0, 1'b0, 1, 3, r, el, cl, aoe, roe, early, tmo, pz);
    exp = m_read(4'b0100, 16, 1'b1);
    checks++;
    if (r !== exp) $display("FAIL illegal_unchanged: got %h expected %h", r, exp);
    else passes++;
    checks++;
    if (el != 4 || cl != 7) $display("FAIL stall_latency: got en %0d clk %0d expected en 4 clk 7", el, cl);
    else passes++;
  endtask

  task automatic test_random;
    logic [63:0] r, d, exp;
    logic [3:0]  w;
    logic        rd, j;
    int unsigned off;
    int el, cl;
    logic aoe, roe, early, tmo, pz;
    for (int n = 0; n < 60; n++) begin
      rd  = 1'($urandom);
      j   = 1'($urandom);
      off = $urandom_range(0, 63);
      d   = {$urandom, $urandom};
      w   = 4'b0001 << $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) begin
        w = 4'($urandom);
        while ($countones(w) == 1) w = 4'($urandom);
      end
      exp = m_read(w, off, j);
      run_cycle(rd, w, j, 24'hF1B000 + 24'(off), d, 1'b0, 1'b1, 0, 0, r, el, cl, aoe, roe, early, tmo, pz);
      if (!rd) m_write(w, off, j, d);
      checks++;
      if ({tmo, aoe, roe, early, pz} !== {2'b01, rd, 2'b01} || el != WS + 2)
        $display("FAIL rand%0d_ctl: flags %b lat %0d expected %b lat %0d", n, {tmo, aoe, roe, early, pz}, el, {2'b01, rd, 2'b01}, WS + 2);
      else passes++;
      if (rd) begin
        checks++;
        if (r !== exp) $display("FAIL rand%0d_data: w %b off %0d j %b got %h expected %h", n, w, off, j, r, exp);
        else passes++;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    init_mem();
    test_long_rw();
    test_byte_phrase();
    test_miss();
    test_back_to_back();
    test_reset_abort();
    test_illegal_stall();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
